bcd_ms_counter: RTL and testbench
=================================

# bcd_ms_counter

Four-digit decimal millisecond counter (0000–9999 ms) with a start/stop/clear control state machine. It sits directly upstream of the per-digit BCD-to-5421 code converters: each `digitN` output feeds one converter's 4-bit input (A = MSB … D = LSB). The block guarantees that every digit is always a legal BCD value, 0–9, which is the converter's only defined input range.

## Interface
- `TICK_DIV`, 100000: system clocks per millisecond (100 MHz → 1 kHz); legal range ≥ 2. Benches use 4.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `start`  input  1  sampled every cycle; starts or resumes counting.
- `stop`  input  1  sampled every cycle; pauses counting.
- `clear`  input  1  sampled every cycle; zeroes the count and returns to IDLE.
- `digit3`  output  4  thousands digit, BCD.
- `digit2`  output  4  hundreds digit, BCD.
- `digit1`  output  4  tens digit, BCD.
- `digit0`  output  4  units digit (ms), BCD.
- `running`  output  1  high while the state is RUN.
- `ms_tick`  output  1  one-cycle pulse in the cycle in which the count increments.
- `overflow`  output  1  high while the state is OVF (count saturated at 9999).

## Operation
- States: IDLE, RUN, HOLD, OVF. The encoding is free; all outputs are registered.
- Control priority within one cycle: `rst_n` low, then `clear`, then `stop`, then `start`.
- IDLE:
  - `start` → RUN.
  - `stop` is ignored.
- RUN:
  - `stop` → HOLD.
  - `start` is ignored.
  - A prescaler counts 0…TICK_DIV−1, then wraps.
  - The wrap cycle generates the internal tick.
- HOLD:
  - `start` → RUN.
  - The prescaler and digits are frozen; resuming keeps the sub-millisecond phase.
- OVF:
  - `start` and `stop` are ignored.
  - Only `clear` or reset leaves OVF, to IDLE.
- `clear` in any state:
  - Next state is IDLE.
  - All digits become 0 and the prescaler becomes 0.
- Increment rule on a tick:
  - `digit0` increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - The carry ripples through all four digits in the same cycle.
- Saturation:
  - A tick while the count is 9999 does not wrap.
  - Digits stay 9,9,9,9 and the next state is OVF.
  - `ms_tick` does not pulse for this tick.
- A tick in the same cycle as `stop` is applied: the count increments, `ms_tick` pulses, and the state becomes HOLD.
- A tick in the same cycle as `clear` is discarded: the count goes to 0000.
- Prescaler width is clog2(TICK_DIV). The prescaler is cleared on entry to RUN from IDLE only.
- Digits are never outside 0–9 in any state or cycle, including straight out of reset.

## Timing
- Reset values: all digits 0, `running`=0, `ms_tick`=0, `overflow`=0, state IDLE, prescaler 0.
- Reset mid-count takes effect on the next edge, identical to `clear`.
- `start` sampled in IDLE at edge n:
  - `running`=1 after edge n.
  - The prescaler reaches TICK_DIV−1 after edge n+TICK_DIV−1.
  - `digit0`=1 and `ms_tick`=1 after edge n+TICK_DIV.
- Steady RUN: one increment every TICK_DIV cycles. `ms_tick` is high for exactly one cycle, aligned with the new digit values.
- `stop` sampled at edge n: `running`=0 after edge n. No increment occurs after edge n unless the tick coincided with edge n.
- `start` in HOLD at edge n: the remaining prescaler count is resumed, so total RUN cycles between ticks are always TICK_DIV.
- Saturating tick at edge n: `overflow`=1 and `running`=0 after edge n.
- `clear` at edge n: digits read 0000 and `overflow`=0 after edge n.

## Test plan
- TICK_DIV=4; reset, then pulse `start` → `digit0` steps 1, 2, 3 at 4-cycle intervals; `ms_tick` is one cycle wide with each step; `running`=1.
- Run to 0009, then one tick → digits 0010. Run to 0999, then one tick → 1000, with the ripple completing in a single cycle.
- Run to 9999, then one more tick period → digits hold 9999, `overflow`=1, `running`=0, no `ms_tick`. Then `start` → no change. Then `clear` → 0000, IDLE.
- `stop` at prescaler=2 → count frozen for 20 cycles. Then `start` → next increment exactly 2 cycles after resume (4 RUN cycles total since the last tick).
- Same-cycle events:
  - `start`+`stop` in RUN → HOLD.
  - `clear`+tick → 0000 with no `ms_tick`.
  - `stop`+tick → count incremented, then HOLD.
- Drive `rst_n` low for one cycle mid-count at 0347 → all outputs at reset values on the next cycle. Throughout every scenario, assert each digit ≤ 9 on every cycle.

Source files
------------

// File: rtl/bcd_ms_counter.sv
// Four-digit BCD millisecond counter (0000-9999) with IDLE/RUN/HOLD/OVF control.
// A prescaler divides clk by TICK_DIV. Each wrap increments the BCD count with a
// single-cycle ripple carry. The count saturates at 9999 and the block then waits
// in OVF until clear or reset. Every output is registered.
module bcd_ms_counter #(
  parameter int TICK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       running,
  output logic       ms_tick,
  output logic       overflow
);

  localparam int            PW     = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, OVF} state_t;

  state_t              state, state_nx;
  logic [PW-1:0]       presc, presc_nx;
  logic [3:0][3:0]     dig, dig_nx, dig_inc;
  logic                tick, all_nine, tick_nx;

  // The prescaler wraps only while running. The wrap cycle is the millisecond tick.
  assign tick     = (state == RUN) && (presc == PS_MAX);
  assign all_nine = (dig == 16'h9999);

  // BCD increment with the carry rippling through all four digits in one cycle.
  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry && dig[i] == 4'd9) begin
        dig_inc[i] = 4'd0;
      end else if (carry) begin
        dig_inc[i] = dig[i] + 4'd1;
        carry      = 1'b0;
      end else begin
        dig_inc[i] = dig[i];
      end
    end
  end

  // Next-state logic. Priority is clear, then stop, then start.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // value unassigned; otherwise synthesis infers a latch.
    state_nx = state;
    presc_nx = presc;
    dig_nx   = dig;
    tick_nx  = 1'b0;
    if (clear) begin
      // A tick coinciding with clear is discarded.
      state_nx = IDLE;
      presc_nx = '0;
      dig_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state_nx = RUN;
            presc_nx = '0;
          end
        end
        RUN: begin
          presc_nx = tick ? '0 : presc + 1'b1;
          if (tick && all_nine) begin
            // Saturate: hold 9999 and suppress the tick pulse.
            state_nx = OVF;
          end else begin
            if (tick) begin
              dig_nx  = dig_inc;
              tick_nx = 1'b1;
            end
            // A tick in the stop cycle still counts; only later ticks are blocked.
            if (stop) state_nx = HOLD;
          end
        end
        HOLD: begin
          // The prescaler stays frozen, so the sub-millisecond phase survives a pause.
          if (start && !stop) state_nx = RUN;
        end
        OVF: begin
          // Only clear or reset leaves OVF.
        end
      endcase
    end
  end

  // State, count and registered status flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      dig      <= '0;
      running  <= 1'b0;
      ms_tick  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      presc    <= presc_nx;
      dig      <= dig_nx;
      running  <= (state_nx == RUN);
      ms_tick  <= tick_nx;
      overflow <= (state_nx == OVF);
    end
  end

  assign digit3 = dig[3];
  assign digit2 = dig[2];
  assign digit1 = dig[1];
  assign digit0 = dig[0];

endmodule

// File: tb/tb_bcd_ms_counter.sv
// Self-checking bench for bcd_ms_counter with TICK_DIV=4.
// Every cycle, all DUT outputs are compared with an integer-count reference model.
// A directed vector table and hand-written corner sequences add their own checks,
// followed by a randomized control phase.
module tb_bcd_ms_counter;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       running, ms_tick, overflow;

  int n_checks = 0;
  int n_errors = 0;

  bcd_ms_counter #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .running(running), .ms_tick(ms_tick), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: the count is a plain integer and phase counts RUN cycles.
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_OVF} mstate_t;
  mstate_t m_st    = M_IDLE;
  int      m_count = 0;
  int      m_phase = 0;
  logic    m_tick  = 1'b0;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] dut_bcd();
    return {digit3, digit2, digit1, digit0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic p, input logic c);
    m_tick = 1'b0;
    if (!r || c) begin
      m_st = M_IDLE; m_count = 0; m_phase = 0;
    end else begin
      case (m_st)
        M_IDLE: if (s && !p) begin m_st = M_RUN; m_phase = 0; end
        M_RUN: begin
          m_phase++;
          if (m_phase == TICK_DIV) begin
            m_phase = 0;
            if (m_count == 9999) m_st = M_OVF;
            else begin m_count++; m_tick = 1'b1; end
          end
          if (m_st == M_RUN && p) m_st = M_HOLD;
        end
        M_HOLD: if (s && !p) m_st = M_RUN;
        default: ;
      endcase
    end
  endtask

  // One clock: drive inputs, step the model at the edge, then compare 1 ns later.
  task automatic cycle(input logic r, input logic s, input logic p, input logic c);
    rst_n = r; start = s; stop = p; clear = c;
    @(posedge clk);
    model_step(r, s, p, c);
    #1;
    check("digits",   dut_bcd(), to_bcd(m_count));
    check("running",  running,   m_st == M_RUN);
    check("ms_tick",  ms_tick,   m_tick);
    check("overflow", overflow,  m_st == M_OVF);
    check("digit_range",
          (digit3 <= 4'd9) && (digit2 <= 4'd9) && (digit1 <= 4'd9) && (digit0 <= 4'd9), 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Run until the DUT shows the target count, bounded by a cycle budget.
  task automatic run_until(input int target);
    int budget;
    budget = (target + 2) * TICK_DIV + 16;
    while (dut_bcd() !== to_bcd(target) && budget > 0) begin
      idle(1);
      budget--;
    end
    check($sformatf("reach_%0d", target), dut_bcd(), to_bcd(target));
  endtask

  // Run until the DUT pulses ms_tick, bounded.
  task automatic wait_tick();
    int budget;
    budget = 2 * TICK_DIV + 2;
    do begin
      idle(1);
      budget--;
    end while (ms_tick !== 1'b1 && budget > 0);
    check("wait_tick", ms_tick, 1'b1);
  endtask

  typedef struct {
    logic r, s, p, c;
    int   cnt;
    logic run, tck, ovf;
  } vec_t;

  initial begin
    vec_t       vecs[22];
    logic [15:0] frozen;

    // Directed table: reset, start, three ticks, start+stop in RUN, resume, clear.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 22; i++) begin
      cycle(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].c);
      check($sformatf("vec%0d_digits", i),   dut_bcd(), to_bcd(vecs[i].cnt));
      check($sformatf("vec%0d_running", i),  running,   vecs[i].run);
      check($sformatf("vec%0d_ms_tick", i),  ms_tick,   vecs[i].tck);
      check($sformatf("vec%0d_overflow", i), overflow,  vecs[i].ovf);
    end

    // Stop when the prescaler reads 2; resume needs exactly 2 more RUN cycles.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    wait_tick();
    idle(1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("stop_running", running, 1'b0);
    frozen = dut_bcd();
    idle(20);
    check("hold_frozen", dut_bcd(), frozen);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("resume_running", running, 1'b1);
    check("resume_no_tick0", ms_tick, 1'b0);
    idle(1);
    check("resume_no_tick1", ms_tick, 1'b0);
    idle(1);
    check("resume_tick", ms_tick, 1'b1);
    check("resume_digits", dut_bcd(), frozen + 16'h1);

    // Clear coinciding with a tick: count goes to 0000 with no pulse.
    wait_tick();
    idle(TICK_DIV - 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("clear_tick_digits", dut_bcd(), 16'h0000);
    check("clear_tick_no_pulse", ms_tick, 1'b0);

    // Stop coinciding with a tick: increment applies, then HOLD.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    wait_tick();
    idle(TICK_DIV - 1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("stop_tick_digits", dut_bcd(), 16'h0002);
    check("stop_tick_pulse", ms_tick, 1'b1);
    check("stop_tick_running", running, 1'b0);
    idle(8);
    check("stop_tick_frozen", dut_bcd(), 16'h0002);

    // Reset mid-count at 0347.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    run_until(347);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_digits", dut_bcd(), 16'h0000);
    check("rst_running", running, 1'b0);
    check("rst_ms_tick", ms_tick, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    idle(6);
    check("rst_stays_idle", dut_bcd(), 16'h0000);

    // Ripple carries and saturation.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    run_until(9);
    run_until(10);
    check("ripple_0010_tick", ms_tick, 1'b1);
    run_until(999);
    run_until(1000);
    check("ripple_1000_tick", ms_tick, 1'b1);
    run_until(9999);
    idle(TICK_DIV);
    check("sat_digits", dut_bcd(), 16'h9999);
    check("sat_overflow", overflow, 1'b1);
    check("sat_running", running, 1'b0);
    check("sat_no_tick", ms_tick, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(TICK_DIV * 2);
    check("ovf_start_ignored", dut_bcd(), 16'h9999);
    check("ovf_still_set", overflow, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("ovf_clear_digits", dut_bcd(), 16'h0000);
    check("ovf_clear_flag", overflow, 1'b0);
    check("ovf_clear_idle", running, 1'b0);

    // Randomized control traffic against the model (start/stop never together).
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cycle(r != 14, r < 8, r >= 8 && r < 12, r == 13);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
